alu_iter: RTL and testbench
===========================

# alu_iter

Parametrised, sequential successor to the team's 8-bit combinational ALU. It accepts one operation per valid/ready handshake and computes the arithmetic or logic result. It then applies a multi-bit shift iteratively, one bit per clock, and presents the result with status flags, holding them until the downstream consumer takes them. It sits between the instruction decode stage (upstream) and the register writeback stage (downstream).

## Interface
- WIDTH, 8: datapath width; power of two, >= 4.
- SHW, $clog2(WIDTH): shift-amount width, derived; do not override.

- alu_clk_in  input  1  clock; all state updates on rising edge.
- alu_rst_in  input  1  reset; asynchronous, active-high.
- alu_valid_in  input  1  upstream operation valid.
- alu_ready_out  output  1  block can accept an operation; high only in IDLE.
- alu_sel_in  input  5  operation select, same S4..S0 encoding as existing ALU.
- alu_carry_in  input  1  arithmetic carry-in.
- alu_a_in  input  WIDTH  operand A.
- alu_b_in  input  WIDTH  operand B.
- alu_shamt_in  input  SHW  shift distance, 0..WIDTH-1.
- alu_valid_out  output  1  result valid; high only in HOLD.
- alu_ready_in  input  1  downstream accepts result.
- alu_y_out  output  WIDTH  result, registered.
- alu_flags_out  output  4  {carry, ovf, neg, zero}, registered.

## Operation
- FSM states: IDLE, SHIFT, HOLD. Reset state is IDLE.
- IDLE: alu_ready_out=1. On alu_valid_in && alu_ready_out, register the unshifted result, flags and shift count, then:
  - go to SHIFT if sel[4:3] is 01 or 10 and shamt != 0;
  - otherwise go to HOLD.
- Arithmetic (sel[2]=0): sum = A + X + c, computed at WIDTH+1 bits. The {sel[1:0],cin} pairs give:
  - 000: X=0, c=0
  - 001: X=0, c=1
  - 010: X=B, c=0
  - 011: X=B, c=1
  - 100: X=~B, c=0
  - 101: X=~B, c=1
  - 110: X=all-ones, c=0
  - 111: X=0, c=0
- Arithmetic flags: carry = sum[WIDTH]; ovf = (A[msb]==X[msb]) && (sum[msb]!=A[msb]).
- Logic (sel[2]=1): sel[1:0] 00 AND, 01 OR, 10 XOR, 11 ~A. alu_carry_in is ignored; carry=0, ovf=0.
- Shift (sel[4:3]):
  - 00: no shift.
  - 01: logical left.
  - 10: logical right.
  - 11: result 0 with flags {0,0,0,1}; shamt is ignored and there is no SHIFT phase.
- SHIFT: each cycle, shift the result register by 1 bit (zero fill) and decrement the count. carry = the bit shifted out; ovf is cleared. When the count reaches 0, go to HOLD.
- neg = result[msb] and zero = (result==0) are evaluated on the final (post-shift) result.
- HOLD: alu_valid_out=1; alu_y_out and alu_flags_out are stable. When alu_ready_in=1, go to IDLE on the next edge.
- No accept in SHIFT or HOLD; alu_valid_in is ignored there. Operands are captured at accept, so input changes afterwards have no effect.

## Timing
- Reset (async, any state, including mid-SHIFT): state IDLE, alu_valid_out=0, alu_ready_out=1, alu_y_out=0, alu_flags_out=0. Any in-flight operation is discarded.
- Accept at edge k with effective shift s (s=0 for shift mode 00 or 11):
  - alu_valid_out rises after edge k+s;
  - latency is 1+s cycles from the accept cycle.
- Handshake completes at the first edge with valid_out && ready_in. alu_ready_out rises after that edge.
- Minimum issue interval: 2+s cycles.
- Arithmetic wraps modulo 2^WIDTH.

## Test plan
- WIDTH=8, sel=00001, cin=1, A=0x7F, B=0x01, shamt=0 -> y=0x81, flags carry=0, ovf=1, neg=1, zero=0; valid_out one cycle after accept.
- sel=00010, cin=1, A=0x05, B=0x05 -> y=0x00, carry=1, ovf=0, zero=1.
- sel=01001, cin=0, A=0x81, B=0x00, shamt=1 -> y=0x02, carry=1; sel=10111, A=0x0F, shamt=2 -> y=0x3C, carry=0, neg=0; valid_out rises after edge k+shamt.
- sel=11000, shamt=5, any A/B -> y=0x00, flags 0001, latency 1 cycle.
- HOLD with ready_in=0 for 4 cycles while valid_in=1 with new operands -> y and flags stable, ready_out=0, no new accept; ready_in=1 -> IDLE and ready_out=1 next cycle, then the new op is accepted.
- Reset pulse during SHIFT (shamt=7, third shift cycle) -> immediately valid_out=0, y=0, flags=0, ready_out=1; the aborted result is never presented.

Source files
------------

// File: rtl/alu_iter.sv
// alu_iter: sequential ALU with an iterative one-bit-per-cycle shifter.
// An operation is accepted in IDLE, the arithmetic/logic result is computed
// combinationally and registered, then optionally shifted in SHIFT, and finally
// presented in HOLD until the downstream stage takes it.
module alu_iter #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             alu_clk_in,
    input  logic             alu_rst_in,
    input  logic             alu_valid_in,
    output logic             alu_ready_out,
    input  logic [4:0]       alu_sel_in,
    input  logic             alu_carry_in,
    input  logic [WIDTH-1:0] alu_a_in,
    input  logic [WIDTH-1:0] alu_b_in,
    input  logic [SHW-1:0]   alu_shamt_in,
    output logic             alu_valid_out,
    input  logic             alu_ready_in,
    output logic [WIDTH-1:0] alu_y_out,
    output logic [3:0]       alu_flags_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_y;
    logic             r_carry;
    logic             r_ovf;
    logic             r_neg;
    logic             r_zero;
    logic [SHW-1:0]   r_cnt;
    logic             r_dir_left;

    logic [WIDTH-1:0] w_x;
    logic             w_c;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_logic;
    logic [WIDTH-1:0] w_res;
    logic             w_res_carry;
    logic             w_res_ovf;
    logic             w_accept;
    logic             w_shift_go;
    logic [WIDTH-1:0] w_shift_y;
    logic             w_shift_out;

    // Second adder operand and carry selected from {sel[1:0], carry-in}
    always_comb begin
        w_x = '0;
        w_c = 1'b0;
        case ({alu_sel_in[1:0], alu_carry_in})
            3'b000: begin w_x = '0;        w_c = 1'b0; end
            3'b001: begin w_x = '0;        w_c = 1'b1; end
            3'b010: begin w_x = alu_b_in;  w_c = 1'b0; end
            3'b011: begin w_x = alu_b_in;  w_c = 1'b1; end
            3'b100: begin w_x = ~alu_b_in; w_c = 1'b0; end
            3'b101: begin w_x = ~alu_b_in; w_c = 1'b1; end
            3'b110: begin w_x = '1;        w_c = 1'b0; end
            default: begin w_x = '0;       w_c = 1'b0; end
        endcase
    end

    assign w_sum = {1'b0, alu_a_in} + {1'b0, w_x} + {{WIDTH{1'b0}}, w_c};

    // Logic unit
    always_comb begin
        w_logic = '0;
        case (alu_sel_in[1:0])
            2'b00:   w_logic = alu_a_in & alu_b_in;
            2'b01:   w_logic = alu_a_in | alu_b_in;
            2'b10:   w_logic = alu_a_in ^ alu_b_in;
            default: w_logic = ~alu_a_in;
        endcase
    end

    // Unshifted result and its carry/overflow; shift mode 11 forces zero
    always_comb begin
        w_res       = '0;
        w_res_carry = 1'b0;
        w_res_ovf   = 1'b0;
        if (alu_sel_in[4:3] == 2'b11) begin
            w_res = '0;
        end else if (alu_sel_in[2] == 1'b0) begin
            w_res       = w_sum[WIDTH-1:0];
            w_res_carry = w_sum[WIDTH];
            w_res_ovf   = (alu_a_in[WIDTH-1] == w_x[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != alu_a_in[WIDTH-1]);
        end else begin
            w_res = w_logic;
        end
    end

    assign w_accept   = alu_valid_in && (r_state == ST_IDLE);
    assign w_shift_go = ((alu_sel_in[4:3] == 2'b01) || (alu_sel_in[4:3] == 2'b10)) &&
                        (alu_shamt_in != '0);

    // One-bit shift step of the result register, zero fill
    assign w_shift_y   = r_dir_left ? {r_y[WIDTH-2:0], 1'b0} : {1'b0, r_y[WIDTH-1:1]};
    assign w_shift_out = r_dir_left ? r_y[WIDTH-1] : r_y[0];

    // State register
    always_ff @(posedge alu_clk_in or posedge alu_rst_in) begin
        if (alu_rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        w_state_next  = r_state;
        alu_ready_out = 1'b0;
        alu_valid_out = 1'b0;
        case (r_state)
            ST_IDLE: begin
                alu_ready_out = 1'b1;
                if (w_accept) begin
                    w_state_next = w_shift_go ? ST_SHIFT : ST_HOLD;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == SHW'(1)) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                alu_valid_out = 1'b1;
                if (alu_ready_in) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Result, flags and shift counter: load on accept, step during SHIFT
    always_ff @(posedge alu_clk_in or posedge alu_rst_in) begin
        if (alu_rst_in) begin
            r_y        <= '0;
            r_carry    <= 1'b0;
            r_ovf      <= 1'b0;
            r_neg      <= 1'b0;
            r_zero     <= 1'b0;
            r_cnt      <= '0;
            r_dir_left <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_accept) begin
                r_y        <= w_res;
                r_carry    <= w_res_carry;
                r_ovf      <= w_res_ovf;
                r_neg      <= w_res[WIDTH-1];
                r_zero     <= (w_res == '0);
                r_cnt      <= alu_shamt_in;
                r_dir_left <= ~alu_sel_in[4];
            end
        end else if (r_state == ST_SHIFT) begin
            r_y     <= w_shift_y;
            r_carry <= w_shift_out;
            r_ovf   <= 1'b0;
            r_neg   <= w_shift_y[WIDTH-1];
            r_zero  <= (w_shift_y == '0);
            r_cnt   <= r_cnt - SHW'(1);
        end
    end

    assign alu_y_out     = r_y;
    assign alu_flags_out = {r_carry, r_ovf, r_neg, r_zero};

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed and randomized checks of alu_iter against an
// arithmetic reference model of the operation rules.
module tb_alu_iter;

    localparam int W   = 8;
    localparam int SHW = $clog2(W);

    logic           clk = 1'b0;
    logic           rst;
    logic           valid_in;
    logic           ready_out;
    logic [4:0]     sel;
    logic           cin;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [SHW-1:0] shamt;
    logic           valid_out;
    logic           ready_in;
    logic [W-1:0]   y;
    logic [3:0]     flags;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_iter #(.WIDTH(W)) dut (
        .alu_clk_in    (clk),
        .alu_rst_in    (rst),
        .alu_valid_in  (valid_in),
        .alu_ready_out (ready_out),
        .alu_sel_in    (sel),
        .alu_carry_in  (cin),
        .alu_a_in      (a),
        .alu_b_in      (b),
        .alu_shamt_in  (shamt),
        .alu_valid_out (valid_out),
        .alu_ready_in  (ready_in),
        .alu_y_out     (y),
        .alu_flags_out (flags)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: whole-operation result from plain integer arithmetic
    function automatic void model(input logic [4:0] m_sel, input logic m_cin,
                                  input int ma, input int mb, input int sh,
                                  output int ry, output int rflags, output int rs);
        int mask;
        int x;
        int c;
        int sum;
        int carry;
        int ovf;
        int res;
        mask  = (1 << W) - 1;
        x     = 0;
        c     = 0;
        carry = 0;
        ovf   = 0;
        rs    = 0;
        if (m_sel[2] == 1'b0) begin
            case ({m_sel[1:0], m_cin})
                3'b001: c = 1;
                3'b010: x = mb;
                3'b011: begin x = mb; c = 1; end
                3'b100: x = ~mb & mask;
                3'b101: begin x = ~mb & mask; c = 1; end
                3'b110: x = mask;
                default: ;
            endcase
            sum   = ma + x + c;
            res   = sum & mask;
            carry = (sum >> W) & 1;
            ovf   = ((((ma >> (W-1)) & 1) == ((x >> (W-1)) & 1)) &&
                     (((res >> (W-1)) & 1) != ((ma >> (W-1)) & 1))) ? 1 : 0;
        end else begin
            case (m_sel[1:0])
                2'b00:   res = ma & mb;
                2'b01:   res = ma | mb;
                2'b10:   res = ma ^ mb;
                default: res = ~ma & mask;
            endcase
        end
        case (m_sel[4:3])
            2'b01: if (sh != 0) begin
                carry = (res >> (W - sh)) & 1;
                res   = (res << sh) & mask;
                ovf   = 0;
                rs    = sh;
            end
            2'b10: if (sh != 0) begin
                carry = (res >> (sh - 1)) & 1;
                res   = res >> sh;
                ovf   = 0;
                rs    = sh;
            end
            2'b11: begin
                res   = 0;
                carry = 0;
                ovf   = 0;
            end
            default: ;
        endcase
        ry     = res;
        rflags = (carry << 3) | (ovf << 2) | (((res >> (W-1)) & 1) << 1) | ((res == 0) ? 1 : 0);
    endfunction

    // One complete transaction: accept, wait for result, hold, release
    task automatic run_op(input logic [4:0] t_sel, input logic t_cin,
                          input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                          input logic [SHW-1:0] t_sh, input int hold);
        int ey;
        int ef;
        int es;
        int n;
        model(t_sel, t_cin, int'(t_a), int'(t_b), int'(t_sh), ey, ef, es);
        @(negedge clk);
        ready_in = 1'b0;
        check_val("idle_ready", ready_out, 1);
        valid_in = 1'b1;
        sel = t_sel; cin = t_cin; a = t_a; b = t_b; shamt = t_sh;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        sel = 5'($urandom); cin = 1'($urandom); a = W'($urandom); b = W'($urandom);
        shamt = SHW'($urandom);
        check_val("busy_ready", ready_out, 0);
        n = 0;
        while (!valid_out && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("latency", n, es);
        check_val("y", y, ey);
        check_val("flags", flags, ef);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            valid_in = 1'b1;
            a = W'($urandom); b = W'($urandom); sel = 5'($urandom); shamt = SHW'($urandom);
            @(posedge clk);
            #1;
            check_val("hold_y", y, ey);
            check_val("hold_flags", flags, ef);
            check_val("hold_ready", ready_out, 0);
            check_val("hold_valid", valid_out, 1);
        end
        @(negedge clk);
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        check_val("rel_ready", ready_out, 1);
        check_val("rel_valid", valid_out, 0);
        $display("op sel=%b cin=%0d a=%h b=%h sh=%0d -> y=%h flags=%b lat=%0d (exp y=%h flags=%b lat=%0d)",
                 t_sel, t_cin, t_a, t_b, t_sh, y, flags, n + 1, ey[W-1:0], ef[3:0], es + 1);
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; ready_in = 1'b0;
        sel = '0; cin = 1'b0; a = '0; b = '0; shamt = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", valid_out, 0);
        check_val("rst_ready", ready_out, 1);
        check_val("rst_y", y, 0);
        check_val("rst_flags", flags, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_op(5'b00001, 1'b1, 8'h7F, 8'h01, 3'd0, 0);
        run_op(5'b00010, 1'b1, 8'h05, 8'h05, 3'd0, 0);
        run_op(5'b01001, 1'b0, 8'h81, 8'h00, 3'd1, 0);
        run_op(5'b10111, 1'b0, 8'h0F, 8'h00, 3'd2, 0);
        run_op(5'b11000, 1'b0, 8'hA5, 8'h5A, 3'd5, 0);
        run_op(5'b00110, 1'b0, 8'h00, 8'h00, 3'd0, 4);
        run_op(5'b01100, 1'b1, 8'hFF, 8'h81, 3'd7, 2);

        // Reset pulse in the third shift cycle discards the operation
        @(negedge clk);
        ready_in = 1'b0;
        valid_in = 1'b1;
        sel = 5'b01011; cin = 1'b0; a = 8'hFF; b = 8'h00; shamt = 3'd7;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("mid_rst_valid", valid_out, 0);
        check_val("mid_rst_ready", ready_out, 1);
        check_val("mid_rst_y", y, 0);
        check_val("mid_rst_flags", flags, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check_val("post_rst_valid", valid_out, 0);
        end
        $display("reset during shift: y=%h flags=%b valid=%0d ready=%0d", y, flags, valid_out, ready_out);

        // Randomized operations
        for (int i = 0; i < 150; i++) begin
            run_op(5'($urandom), 1'($urandom), W'($urandom), W'($urandom),
                   SHW'($urandom_range(0, W-1)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
